amns_operand_bank: RTL

// - Parametrised operand/result store for the AMNS modular multiplier datapath.
// - On load_start_i, streams A, B, M and M'0 from BRAM into internal shift/rotate registers.
// - Presents one WORD_WIDTH block per coefficient to the DSP array each cycle.
// - Accumulates result blocks and streams RES back to BRAM on store_start_i.

---
 rtl/amns_operand_bank.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/amns_operand_bank.sv
// AMNS operand/result bank: loads A, B, M, M'0 from BRAM and stores RES back.
// Define AMNS_BRAM_OUT_REG_EN to register BRAM_dout_i before capture (L=2).
module amns_operand_bank #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_start_i,
  input  logic                  store_start_i,
  input  logic [WORD_WIDTH-1:0] BRAM_dout_i,
  input  logic                  A_rot_i,
  input  logic                  B_shift_i,
  input  logic                  M_rot_i,
  input  logic                  M_p_0_rot_i,
  input  logic                  RES_en_i,
  input  logic [N*WORD_WIDTH-1:0] RES_din_i,
  output logic [N*WORD_WIDTH-1:0] A_o,
  output logic [N*WORD_WIDTH-1:0] B_o,
  output logic [N*WORD_WIDTH-1:0] M_o,
  output logic [N*WORD_WIDTH-1:0] M_p_0_o,
  output logic [WORD_WIDTH-1:0] BRAM_din_o,
  output logic                  BRAM_we_o,
  output logic                  BRAM_en_o,
  output logic [31:0]           BRAM_addr_o,
  output logic                  busy_o,
  output logic                  load_done_o,
  output logic                  store_done_o
);
  localparam int WW    = WORD_WIDTH;
  localparam int NS    = N * S;
  localparam int LWORDS = 3 * NS + N;

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAIN, STORE, DONE
  } state_e;

  state_e state_q, state_d;

  logic [WW-1:0] a_q [NS];
  logic [WW-1:0] a_d [NS];
  logic [WW-1:0] b_q [NS];
  logic [WW-1:0] b_d [NS];
  logic [WW-1:0] m_q [NS];
  logic [WW-1:0] m_d [NS];
  logic [WW-1:0] r_q [NS];
  logic [WW-1:0] r_d [NS];
  logic [WW-1:0] p_q [N];
  logic [WW-1:0] p_d [N];

  logic [31:0] cnt_q, cnt_d;
  logic        op_load_q, op_load_d;
  logic        rd_vld_q, rd_vld_d;
  logic [31:0] rd_idx_q, rd_idx_d;

  logic          cap_vld;
  logic [31:0]   cap_idx;
  logic [WW-1:0] cap_data;
  logic          cap_last;

`ifdef AMNS_BRAM_OUT_REG_EN
  logic          rd2_vld_q;
  logic [31:0]   rd2_idx_q;
  logic [WW-1:0] dout_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rd2_vld_q <= 1'b0;
      rd2_idx_q <= '0;
      dout_q    <= '0;
    end else begin
      rd2_vld_q <= rd_vld_q;
      rd2_idx_q <= rd_idx_q;
      dout_q    <= BRAM_dout_i;
    end
  end

  assign cap_vld  = rd2_vld_q;
  assign cap_idx  = rd2_idx_q;
  assign cap_data = dout_q;
`else
  assign cap_vld  = rd_vld_q;
  assign cap_idx  = rd_idx_q;
  assign cap_data = BRAM_dout_i;
`endif

  assign cap_last = cap_vld && (cap_idx == 32'(LWORDS - 1));

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_start_i)       state_d = LOAD;
        else if (store_start_i) state_d = STORE;
      end
      LOAD:  if (cnt_q == 32'(LWORDS - 1)) state_d = DRAIN;
      DRAIN: if (cap_last) state_d = DONE;
      STORE: if (cnt_q == 32'(NS - 1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    BRAM_en_o    = 1'b0;
    BRAM_we_o    = 1'b0;
    BRAM_addr_o  = '0;
    load_done_o  = 1'b0;
    store_done_o = 1'b0;
    busy_o       = (state_q != IDLE);
    unique case (state_q)
      LOAD: begin
        BRAM_en_o   = 1'b1;
        BRAM_addr_o = 32'(BASE_ADDR) + cnt_q;
      end
      STORE: begin
        BRAM_en_o   = 1'b1;
        BRAM_we_o   = 1'b1;
        BRAM_addr_o = 32'(BASE_ADDR + 4 * NS) + cnt_q;
      end
      DONE: begin
        load_done_o  = op_load_q;
        store_done_o = !op_load_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d     = '0;
    op_load_d = op_load_q;
    if (state_q == LOAD || state_q == STORE) cnt_d = cnt_q + 32'd1;
    if (state_q == IDLE) begin
      if (load_start_i)       op_load_d = 1'b1;
      else if (store_start_i) op_load_d = 1'b0;
    end
    rd_vld_d = (state_q == LOAD);
    rd_idx_d = cnt_q;
  end

  // Register file next state; a capture beats rot/shift on its target
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      a_d[i] = a_q[i];
      b_d[i] = b_q[i];
      m_d[i] = m_q[i];
      r_d[i] = r_q[i];
    end
    for (int j = 0; j < N; j++) p_d[j] = p_q[j];

    if (cap_vld && cap_idx < 32'(NS)) begin
      for (int i = 0; i < NS; i++)
        if (cap_idx == 32'(i)) a_d[i] = cap_data;
    end else if (A_rot_i) begin
      for (int j = 0; j < N; j++)
        for (int k = 0; k < S; k++)
          a_d[j*S+k] = a_q[j*S+(k+1)%S];
    end

    if (cap_vld && cap_idx >= 32'(NS) && cap_idx < 32'(2*NS)) begin
      for (int i = 0; i < NS; i++)
        if (cap_idx == 32'(NS + i)) b_d[i] = cap_data;
    end else if (B_shift_i) begin
      for (int j = 0; j < N; j++)
        for (int k = 0; k < S; k++)
          b_d[j*S+k] = (k == S-1) ? '0 : b_q[j*S+(k+1)%S];
    end

    if (cap_vld && cap_idx >= 32'(2*NS) && cap_idx < 32'(3*NS)) begin
      for (int i = 0; i < NS; i++)
        if (cap_idx == 32'(2*NS + i)) m_d[i] = cap_data;
    end else if (M_rot_i) begin
      for (int j = 0; j < N; j++)
        for (int k = 0; k < S; k++)
          m_d[j*S+k] = m_q[j*S+(k+1)%S];
    end

    if (cap_vld && cap_idx >= 32'(3*NS)) begin
      for (int j = 0; j < N; j++)
        if (cap_idx == 32'(3*NS + j)) p_d[j] = cap_data;
    end else if (M_p_0_rot_i) begin
      for (int j = 0; j < N; j++) p_d[j] = p_q[(j+1)%N];
    end

    if (RES_en_i && state_q != STORE) begin
      for (int j = 0; j < N; j++)
        for (int k = 0; k < S; k++)
          r_d[j*S+k] = (k == S-1) ? RES_din_i[j*WW +: WW]
                                  : r_q[j*S+(k+1)%S];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q     <= '0;
      op_load_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      for (int i = 0; i < NS; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        m_q[i] <= '0;
        r_q[i] <= '0;
      end
      for (int j = 0; j < N; j++) p_q[j] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      op_load_q <= op_load_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
      for (int i = 0; i < NS; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        m_q[i] <= m_d[i];
        r_q[i] <= r_d[i];
      end
      for (int j = 0; j < N; j++) p_q[j] <= p_d[j];
    end
  end

  always_comb begin
    A_o     = '0;
    B_o     = '0;
    M_o     = '0;
    M_p_0_o = '0;
    for (int j = 0; j < N; j++) begin
      A_o[j*WW +: WW]     = a_q[j*S];
      B_o[j*WW +: WW]     = b_q[j*S];
      M_o[j*WW +: WW]     = m_q[j*S];
      M_p_0_o[j*WW +: WW] = p_q[j];
    end
  end

  always_comb begin
    BRAM_din_o = '0;
    if (state_q == STORE)
      for (int i = 0; i < NS; i++)
        if (cnt_q == 32'(i)) BRAM_din_o = r_q[i];
  end

endmodule
